// File: rtl/pds_rx.sv
// pds_rx: receive endpoint of the PDS packet interface.
// A frame is: header, length L, L payload bytes and, optionally, an XOR
// checksum of all preceding bytes. Good packets are buffered and replayed
// on the output stream with a destination mask. Bad packets are drained,
// flagged with a one-cycle error pulse and counted.
// Build option: define PDS_RX_CSUM_EN to carry and check the trailing
// checksum byte. Without it, in_eop sits on the last payload byte and
// err_csum is tied low.
module pds_rx #(
    parameter int NPORTS = 4,
    parameter int MAXLEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [7:0]        in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic [7:0]        out_data,
    output logic [NPORTS-1:0] out_mask,
    output logic              err_frame,
    output logic              err_len,
    output logic              err_csum,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       drop_cnt
);

    localparam int IW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

`ifdef PDS_RX_CSUM_EN
    typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_PAY, ST_CSUM, ST_SEND, ST_DROP} state_e;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_PAY, ST_SEND, ST_DROP} state_e;
`endif

    state_e            state_q, state_d;
    logic [NPORTS-1:0] mask_q, mask_d;
    logic              dest_ok_q, dest_ok_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        cnt_q, cnt_d;      // payload write index, then replay index
    logic              err_frame_q, err_frame_d;
    logic              err_len_q, err_len_d;
    logic [15:0]       pkt_cnt_q, pkt_cnt_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
`ifdef PDS_RX_CSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic              err_csum_q, err_csum_d;
`endif

    logic [7:0]        mem_q [MAXLEN];
    logic              mem_we;

    logic              in_xfer;
    logic              last_pay;
    logic              len_ok;
    logic [NPORTS-1:0] hdr_mask;
    logic              hdr_ok;
    logic              abort;

    assign in_xfer  = in_valid && in_ready;
    assign last_pay = (cnt_q == len_q - 8'd1);
    assign len_ok   = (in_data != 8'd0) && (int'(in_data) <= MAXLEN);

    // Decode the destination of a header byte presented on in_data.
    always_comb begin
        hdr_mask = '0;
        hdr_ok   = 1'b0;
        if (in_data[7]) begin
            hdr_mask = in_data[NPORTS-1:0];
            hdr_ok   = |in_data[NPORTS-1:0];
        end else if (int'(in_data[2:0]) < NPORTS) begin
            hdr_mask = NPORTS'(1) << in_data[2:0];
            hdr_ok   = 1'b1;
        end
    end

    // Next-state logic: framing, length, checksum and replay control.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        mask_d      = mask_q;
        dest_ok_d   = dest_ok_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        err_frame_d = 1'b0;
        err_len_d   = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        mem_we      = 1'b0;
        abort       = 1'b0;
`ifdef PDS_RX_CSUM_EN
        csum_d      = csum_q;
        err_csum_d  = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (in_xfer) begin
                    if (in_sop) begin
                        mask_d    = hdr_mask;
                        dest_ok_d = hdr_ok;
`ifdef PDS_RX_CSUM_EN
                        csum_d    = in_data;
`endif
                        state_d   = ST_LEN;
                    end else begin
                        err_frame_d = 1'b1;
                    end
                end
            end
            ST_LEN: begin
                if (in_xfer) begin
                    len_d = in_data;
                    cnt_d = '0;
`ifdef PDS_RX_CSUM_EN
                    csum_d = csum_q ^ in_data;
`endif
                    if (in_sop) begin
                        err_frame_d = 1'b1;
                        abort       = 1'b1;
                    end else if (!len_ok || !dest_ok_q) begin
                        err_len_d = 1'b1;
                        abort     = 1'b1;
                    end else if (in_eop) begin
                        err_frame_d = 1'b1;
                        abort       = 1'b1;
                    end else begin
                        state_d = ST_PAY;
                    end
                end
            end
            ST_PAY: begin
                if (in_xfer) begin
                    mem_we = 1'b1;
                    cnt_d  = cnt_q + 8'd1;
`ifdef PDS_RX_CSUM_EN
                    csum_d = csum_q ^ in_data;
                    if (in_sop || in_eop) begin
                        err_frame_d = 1'b1;
                        abort       = 1'b1;
                    end else if (last_pay) begin
                        cnt_d   = '0;
                        state_d = ST_CSUM;
                    end
`else
                    if (in_sop || (in_eop != last_pay)) begin
                        err_frame_d = 1'b1;
                        abort       = 1'b1;
                    end else if (last_pay) begin
                        cnt_d   = '0;
                        state_d = ST_SEND;
                    end
`endif
                end
            end
`ifdef PDS_RX_CSUM_EN
            ST_CSUM: begin
                if (in_xfer) begin
                    if (in_sop || !in_eop) begin
                        err_frame_d = 1'b1;
                        abort       = 1'b1;
                    end else if (in_data != csum_q) begin
                        err_csum_d = 1'b1;
                        drop_cnt_d = drop_cnt_q + 16'd1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
`endif
            ST_SEND: begin
                if (out_ready) begin
                    if (last_pay) begin
                        pkt_cnt_d = pkt_cnt_q + 16'd1;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_DROP: begin
                if (in_xfer && in_eop) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A rejected byte either ends the packet or starts draining it.
        if (abort) begin
            if (in_eop) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
                state_d    = ST_IDLE;
            end else begin
                state_d = ST_DROP;
            end
        end
    end

    // State and control registers; reset aborts any packet in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            dest_ok_q   <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            err_frame_q <= 1'b0;
            err_len_q   <= 1'b0;
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
`ifdef PDS_RX_CSUM_EN
            csum_q      <= '0;
            err_csum_q  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            mask_q      <= mask_d;
            dest_ok_q   <= dest_ok_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            err_frame_q <= err_frame_d;
            err_len_q   <= err_len_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
`ifdef PDS_RX_CSUM_EN
            csum_q      <= csum_d;
            err_csum_q  <= err_csum_d;
`endif
        end
    end

    // Payload buffer write port.
    // NOTE: the buffer has no reset; it is only read in SEND, after every
    // replayed entry has been written, and out_data is gated outside SEND.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[cnt_q[IW-1:0]] <= in_data;
        end
    end

    assign in_ready  = (state_q != ST_SEND);
    assign out_valid = (state_q == ST_SEND);
    assign out_data  = out_valid ? mem_q[cnt_q[IW-1:0]] : 8'h00;
    assign out_sop   = out_valid && (cnt_q == 8'd0);
    assign out_eop   = out_valid && last_pay;
    assign out_mask  = out_valid ? mask_q : '0;
    assign err_frame = err_frame_q;
    assign err_len   = err_len_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`ifdef PDS_RX_CSUM_EN
    assign err_csum  = err_csum_q;
`else
    assign err_csum  = 1'b0;
`endif

endmodule

// File: tb/tb_pds_rx.sv
// tb_pds_rx: directed self-checking bench for pds_rx (NPORTS=4, MAXLEN=16).
// Works with or without PDS_RX_CSUM_EN; checksum bytes are hand-computed.
module tb_pds_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sop;
    logic        in_eop;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic [7:0]  out_data;
    logic [3:0]  out_mask;
    logic        err_frame;
    logic        err_len;
    logic        err_csum;
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_pkt;
    logic [15:0] exp_drop;

    pds_rx #(.NPORTS(4), .MAXLEN(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .err_frame (err_frame),
        .err_len   (err_len),
        .err_csum  (err_csum),
        .pkt_cnt   (pkt_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present one byte, wait (bounded) for in_ready, complete the transfer.
    task automatic drive(input logic [7:0] d, input logic sop, input logic eop);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_sop   = sop;
        in_eop   = eop;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drive_ready", 16'(in_ready), 16'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    // Check the current output beat, then let it hand off (out_ready = 1).
    task automatic expect_byte(input string tag, input logic [7:0] d,
                               input logic sop, input logic eop, input logic [3:0] mask);
        check({tag, "_valid"}, 16'(out_valid), 16'd1);
        check({tag, "_data"},  16'(out_data),  16'(d));
        check({tag, "_sop"},   16'(out_sop),   16'(sop));
        check({tag, "_eop"},   16'(out_eop),   16'(eop));
        check({tag, "_mask"},  16'(out_mask),  16'(mask));
        cycle();
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        exp_pkt   = 16'd0;
        exp_drop  = 16'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready",  16'(in_ready),  16'd1);
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_out_data",  16'(out_data),  16'd0);
        check("rst_out_mask",  16'(out_mask),  16'd0);
        check("rst_err_frame", 16'(err_frame), 16'd0);
        check("rst_pkt_cnt",   pkt_cnt,        16'd0);
        check("rst_drop_cnt",  drop_cnt,       16'd0);
        rst = 1'b1;
        cycle();

        // 1) single port 2, L=3; checksum 02^03^A1^B2^C3 = D1
        drive(8'h02, 1'b1, 1'b0);
        drive(8'h03, 1'b0, 1'b0);
        drive(8'hA1, 1'b0, 1'b0);
        drive(8'hB2, 1'b0, 1'b0);
`ifdef PDS_RX_CSUM_EN
        drive(8'hC3, 1'b0, 1'b0);
        drive(8'hD1, 1'b0, 1'b1);
`else
        drive(8'hC3, 1'b0, 1'b1);
`endif
        check("t1_in_ready_send", 16'(in_ready), 16'd0);
        expect_byte("t1_b0", 8'hA1, 1'b1, 1'b0, 4'b0100);
        expect_byte("t1_b1", 8'hB2, 1'b0, 1'b0, 4'b0100);
        expect_byte("t1_b2", 8'hC3, 1'b0, 1'b1, 4'b0100);
        exp_pkt = 16'd1;
        check("t1_in_ready_after", 16'(in_ready), 16'd1);
        check("t1_out_valid_after", 16'(out_valid), 16'd0);
        check("t1_pkt_cnt", pkt_cnt, exp_pkt);

        // 2) multicast 0x8B (mask 1011), L=1, backpressure 5 cycles; csum 8B^01^55 = DF
        out_ready = 1'b0;
        drive(8'h8B, 1'b1, 1'b0);
        drive(8'h01, 1'b0, 1'b0);
`ifdef PDS_RX_CSUM_EN
        drive(8'h55, 1'b0, 1'b0);
        drive(8'hDF, 1'b0, 1'b1);
`else
        drive(8'h55, 1'b0, 1'b1);
`endif
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", 16'(out_valid), 16'd1);
            check("t2_hold_data",  16'(out_data),  16'h55);
            check("t2_hold_sop",   16'(out_sop),   16'd1);
            check("t2_hold_eop",   16'(out_eop),   16'd1);
            check("t2_hold_mask",  16'(out_mask),  16'hB);
            check("t2_hold_ready", 16'(in_ready),  16'd0);
            cycle();
        end
        out_ready = 1'b1;
        expect_byte("t2_b0", 8'h55, 1'b1, 1'b1, 4'b1011);
        exp_pkt = 16'd2;
        check("t2_in_ready_after", 16'(in_ready), 16'd1);
        check("t2_pkt_cnt", pkt_cnt, exp_pkt);

        // 3) wrong checksum (D1 ^ 01 = D0)
`ifdef PDS_RX_CSUM_EN
        drive(8'h02, 1'b1, 1'b0);
        drive(8'h03, 1'b0, 1'b0);
        drive(8'hA1, 1'b0, 1'b0);
        drive(8'hB2, 1'b0, 1'b0);
        drive(8'hC3, 1'b0, 1'b0);
        drive(8'hD0, 1'b0, 1'b1);
        exp_drop = exp_drop + 16'd1;
        check("t3_err_csum", 16'(err_csum), 16'd1);
        check("t3_out_valid", 16'(out_valid), 16'd0);
        check("t3_drop_cnt", drop_cnt, exp_drop);
        cycle();
        check("t3_err_csum_clear", 16'(err_csum), 16'd0);
        check("t3_out_valid_clear", 16'(out_valid), 16'd0);
        check("t3_pkt_cnt", pkt_cnt, exp_pkt);
`else
        check("t3_err_csum_tied", 16'(err_csum), 16'd0);
`endif

        // 4) L = 0: err_len, drain to in_eop
        drive(8'h02, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        check("t4_err_len", 16'(err_len), 16'd1);
        check("t4_drop_hold", drop_cnt, exp_drop);
        drive(8'h77, 1'b0, 1'b0);
        check("t4_err_len_clear", 16'(err_len), 16'd0);
        drive(8'h88, 1'b0, 1'b1);
        exp_drop = exp_drop + 16'd1;
        check("t4_drop_cnt", drop_cnt, exp_drop);
        check("t4_out_valid", 16'(out_valid), 16'd0);

        // 5) single-port header 0x05 with 4 ports: invalid destination
        drive(8'h05, 1'b1, 1'b0);
        drive(8'h02, 1'b0, 1'b0);
        check("t5_err_len", 16'(err_len), 16'd1);
        drive(8'h11, 1'b0, 1'b0);
        check("t5_err_len_clear", 16'(err_len), 16'd0);
        drive(8'h22, 1'b0, 1'b1);
        exp_drop = exp_drop + 16'd1;
        check("t5_drop_cnt", drop_cnt, exp_drop);
        check("t5_out_valid", 16'(out_valid), 16'd0);

        // 6) byte without in_sop in IDLE
        drive(8'h99, 1'b0, 1'b0);
        check("t6_err_frame", 16'(err_frame), 16'd1);
        check("t6_drop_hold", drop_cnt, exp_drop);
        check("t6_in_ready", 16'(in_ready), 16'd1);
        cycle();
        check("t6_err_frame_clear", 16'(err_frame), 16'd0);

        // 7) early in_eop on payload byte 1 of L = 4, then a normal packet
        drive(8'h01, 1'b1, 1'b0);
        drive(8'h04, 1'b0, 1'b0);
        drive(8'h10, 1'b0, 1'b0);
        drive(8'h20, 1'b0, 1'b1);
        exp_drop = exp_drop + 16'd1;
        check("t7_err_frame", 16'(err_frame), 16'd1);
        check("t7_drop_cnt", drop_cnt, exp_drop);
        cycle();
        check("t7_err_frame_clear", 16'(err_frame), 16'd0);
        // port 0, L=2; csum 00^02^5A^A5 = FD
        drive(8'h00, 1'b1, 1'b0);
        drive(8'h02, 1'b0, 1'b0);
        drive(8'h5A, 1'b0, 1'b0);
`ifdef PDS_RX_CSUM_EN
        drive(8'hA5, 1'b0, 1'b0);
        drive(8'hFD, 1'b0, 1'b1);
`else
        drive(8'hA5, 1'b0, 1'b1);
`endif
        expect_byte("t7_b0", 8'h5A, 1'b1, 1'b0, 4'b0001);
        expect_byte("t7_b1", 8'hA5, 1'b0, 1'b1, 4'b0001);
        exp_pkt = exp_pkt + 16'd1;
        check("t7_pkt_cnt", pkt_cnt, exp_pkt);

        // 8) reset during PAY byte 2, then a fresh packet
        drive(8'h03, 1'b1, 1'b0);
        drive(8'h04, 1'b0, 1'b0);
        drive(8'h01, 1'b0, 1'b0);
        drive(8'h02, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h03;
        rst      = 1'b0;
        #1;
        check("t8_in_ready",  16'(in_ready),  16'd1);
        check("t8_out_valid", 16'(out_valid), 16'd0);
        check("t8_out_sop",   16'(out_sop),   16'd0);
        check("t8_out_eop",   16'(out_eop),   16'd0);
        check("t8_out_data",  16'(out_data),  16'd0);
        check("t8_out_mask",  16'(out_mask),  16'd0);
        check("t8_err_frame", 16'(err_frame), 16'd0);
        check("t8_err_len",   16'(err_len),   16'd0);
        check("t8_err_csum",  16'(err_csum),  16'd0);
        check("t8_pkt_cnt",   pkt_cnt,        16'd0);
        check("t8_drop_cnt",  drop_cnt,       16'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cycle();
        // multicast 0x83 (mask 0011), L=1; csum 83^01^3C = BE
        drive(8'h83, 1'b1, 1'b0);
        drive(8'h01, 1'b0, 1'b0);
`ifdef PDS_RX_CSUM_EN
        drive(8'h3C, 1'b0, 1'b0);
        drive(8'hBE, 1'b0, 1'b1);
`else
        drive(8'h3C, 1'b0, 1'b1);
`endif
        expect_byte("t8_b0", 8'h3C, 1'b1, 1'b1, 4'b0011);
        check("t8_pkt_after", pkt_cnt, 16'd1);
        check("t8_drop_after", drop_cnt, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
